// File: rtl/rv32_decode_stage.sv
// RV32 decode stage: classifies each instruction (one-hot class plus legality)
// and holds results in a 2-entry FIFO so in_ready never depends on out_ready.
module rv32_decode_stage #(
  parameter int PC_W        = 32,
  parameter int SUPPORT_M   = 0,
  parameter int SUPPORT_SYS = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [10:0]      out_class,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [10:0] w_class_raw;
  logic [10:0] w_class;
  logic        w_legal;
  logic        w_illegal;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_f7     = in_instr[31:25];

  // Every mapped opcode ends in 2'b11, so unmapped words cover the bits[1:0] check.
  always_comb begin
    w_class_raw = '0;
    w_legal     = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_class_raw[0] = 1'b1;
        w_legal = (w_f7 == F7_ZERO)
               || ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)))
               || ((w_f7 == F7_MUL) && (SUPPORT_M != 0));
      end
      OP_I: begin
        w_class_raw[1] = 1'b1;
        case (w_f3)
          3'b001:  w_legal = (w_f7 == F7_ZERO);
          3'b101:  w_legal = (w_f7 == F7_ZERO) || (w_f7 == F7_ALT);
          default: w_legal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_class_raw[2] = 1'b1;
        w_legal = (w_f3 != 3'b011) && (w_f3 != 3'b110) && (w_f3 != 3'b111);
      end
      OP_STORE: begin
        w_class_raw[3] = 1'b1;
        w_legal = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010);
      end
      OP_BRANCH: begin
        w_class_raw[4] = 1'b1;
        w_legal = (w_f3 != 3'b010) && (w_f3 != 3'b011);
      end
      OP_JAL: begin
        w_class_raw[5] = 1'b1;
        w_legal = 1'b1;
      end
      OP_JALR: begin
        w_class_raw[6] = 1'b1;
        w_legal = (w_f3 == 3'b000);
      end
      OP_AUIPC: begin
        w_class_raw[7] = 1'b1;
        w_legal = 1'b1;
      end
      OP_LUI: begin
        w_class_raw[8] = 1'b1;
        w_legal = 1'b1;
      end
      OP_FENCE: begin
        w_class_raw[9] = 1'b1;
        w_legal = (SUPPORT_SYS != 0) && (w_f3 == 3'b000);
      end
      OP_SYSTEM: begin
        // Only ECALL and EBREAK; all CSR forms are rejected.
        w_class_raw[10] = 1'b1;
        w_legal = (SUPPORT_SYS != 0)
               && ((in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073));
      end
      default: begin
        w_class_raw = '0;
        w_legal     = 1'b0;
      end
    endcase
  end

  assign w_illegal = !w_legal;
  assign w_class   = w_legal ? w_class_raw : 11'd0;

  // Handshake: a beat transfers on a rising edge where valid && ready are both high;
  // the producer holds valid and payload stable until that edge, and ready is
  // computed only from registered occupancy plus rst/flush, never from out_ready.
  logic [31:0]     r_instr [2];
  logic [PC_W-1:0] r_pc    [2];
  logic [10:0]     r_class [2];
  logic            r_ill   [2];
  logic [1:0]      r_cnt;
  logic            r_rd_ptr;
  logic [CNT_W-1:0] r_illegal_cnt;

  logic w_wr_ptr;
  logic w_push;
  logic w_pop;

  assign in_ready  = !rst && (r_cnt != 2'd2) && !flush;
  assign out_valid = (r_cnt != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready && !flush;
  assign w_wr_ptr  = r_rd_ptr ^ (r_cnt == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= 2'd0;
      r_rd_ptr      <= 1'b0;
      r_illegal_cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_class[i] <= '0;
        r_ill[i]   <= 1'b0;
      end
    end else if (flush) begin
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_instr[w_wr_ptr] <= in_instr;
        r_pc[w_wr_ptr]    <= in_pc;
        r_class[w_wr_ptr] <= w_class;
        r_ill[w_wr_ptr]   <= w_illegal;
        if (w_illegal && (r_illegal_cnt != {CNT_W{1'b1}}))
          r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  assign out_instr   = r_instr[r_rd_ptr];
  assign out_pc      = r_pc[r_rd_ptr];
  assign out_class   = r_class[r_rd_ptr];
  assign out_illegal = r_ill[r_rd_ptr];
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage: a default instance (no M, SYSTEM on, 8-bit
// counter) and a variant (M on, SYSTEM off, 2-bit counter) share one stimulus.
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_instr, a_out_pc;
  logic [10:0] a_out_class;
  logic [7:0]  a_illegal_cnt;

  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_instr, b_out_pc;
  logic [10:0] b_out_class;
  logic [1:0]  b_illegal_cnt;

  int total = 0;
  int bad   = 0;
  int cnt_a = 0;
  int cnt_b = 0;

  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [31:0] instr;
    logic [10:0] ca;
    logic        ia;
    logic [10:0] cb;
    logic        ib;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  rv32_decode_stage #(.PC_W(32), .SUPPORT_M(0), .SUPPORT_SYS(1), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_out_instr), .out_pc(a_out_pc), .out_class(a_out_class),
    .out_illegal(a_out_illegal), .illegal_cnt(a_illegal_cnt)
  );

  rv32_decode_stage #(.PC_W(32), .SUPPORT_M(1), .SUPPORT_SYS(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_out_instr), .out_pc(b_out_pc), .out_class(b_out_class),
    .out_illegal(b_out_illegal), .illegal_cnt(b_illegal_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 32'h0;

    // ---------------- reset state
    tick(); tick();
    chk("in_ready_in_rst", 64'(a_in_ready), 64'(1'b0));
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'(1'b0));
    chk("rst_in_ready", 64'(a_in_ready), 64'(1'b1));
    chk("rst_out_class", 64'(a_out_class), 64'(11'h0));
    chk("rst_out_illegal", 64'(a_out_illegal), 64'(1'b0));
    chk("rst_out_instr", 64'(a_out_instr), 64'(32'h0));
    chk("rst_out_pc", 64'(a_out_pc), 64'(32'h0));
    chk("rst_cnt_a", 64'(a_illegal_cnt), 64'(8'h0));
    chk("rst_cnt_b", 64'(b_illegal_cnt), 64'(2'h0));

    // ---------------- decode stream, out_ready high, one beat per cycle
    vq.push_back({32'h003100B3, 11'h001, 1'b0, 11'h001, 1'b0}); // add
    vq.push_back({32'h00A00093, 11'h002, 1'b0, 11'h002, 1'b0}); // addi
    vq.push_back({32'h0000A103, 11'h004, 1'b0, 11'h004, 1'b0}); // lw
    vq.push_back({32'h0020A023, 11'h008, 1'b0, 11'h008, 1'b0}); // sw
    vq.push_back({32'h023100B3, 11'h000, 1'b1, 11'h001, 1'b0}); // mul
    vq.push_back({32'h00000000, 11'h000, 1'b1, 11'h000, 1'b1});
    vq.push_back({32'h0000B003, 11'h000, 1'b1, 11'h000, 1'b1}); // load f3=011
    vq.push_back({32'h0020A0E3, 11'h000, 1'b1, 11'h000, 1'b1}); // branch f3=010
    vq.push_back({32'h30002073, 11'h000, 1'b1, 11'h000, 1'b1}); // csrrs
    vq.push_back({32'h00000073, 11'h400, 1'b0, 11'h000, 1'b1}); // ecall
    vq.push_back({32'h00100073, 11'h400, 1'b0, 11'h000, 1'b1}); // ebreak
    vq.push_back({32'h0000000F, 11'h200, 1'b0, 11'h000, 1'b1}); // fence
    vq.push_back({32'h403100B3, 11'h001, 1'b0, 11'h001, 1'b0}); // sub
    vq.push_back({32'h40009093, 11'h000, 1'b1, 11'h000, 1'b1}); // slli bad funct7
    vq.push_back({32'h4000D093, 11'h002, 1'b0, 11'h002, 1'b0}); // srai
    vq.push_back({32'h00000067, 11'h040, 1'b0, 11'h040, 1'b0}); // jalr
    vq.push_back({32'h0000106F, 11'h020, 1'b0, 11'h020, 1'b0}); // jal
    vq.push_back({32'h000012B7, 11'h100, 1'b0, 11'h100, 1'b0}); // lui
    vq.push_back({32'h00001297, 11'h080, 1'b0, 11'h080, 1'b0}); // auipc
    vq.push_back({32'h00001067, 11'h000, 1'b1, 11'h000, 1'b1}); // jalr f3=001
    vq.push_back({32'h00209063, 11'h010, 1'b0, 11'h010, 1'b0}); // bne
    vq.push_back({32'h0000C003, 11'h004, 1'b0, 11'h004, 1'b0}); // lbu
    vq.push_back({32'h0000B023, 11'h000, 1'b1, 11'h000, 1'b1}); // store f3=011
    vq.push_back({32'h00000031, 11'h000, 1'b1, 11'h000, 1'b1}); // bits[1:0]=01

    for (int i = 0; i < vq.size(); i++) begin
      in_valid = 1'b1;
      in_instr = vq[i].instr;
      in_pc    = 32'h1000 + 32'(4 * i);
      #1;
      chk($sformatf("in_ready[%0d]", i), 64'(a_in_ready), 64'(1'b1));
      if (vq[i].ia && cnt_a != 255) cnt_a++;
      if (vq[i].ib && cnt_b != 3) cnt_b++;
      tick();
      chk($sformatf("valid[%0d]", i), 64'(a_out_valid), 64'(1'b1));
      chk($sformatf("instr[%0d]", i), 64'(a_out_instr), 64'(vq[i].instr));
      chk($sformatf("pc[%0d]", i), 64'(a_out_pc), 64'(32'h1000 + 32'(4 * i)));
      chk($sformatf("class_a[%0d]", i), 64'(a_out_class), 64'(vq[i].ca));
      chk($sformatf("ill_a[%0d]", i), 64'(a_out_illegal), 64'(vq[i].ia));
      chk($sformatf("cnt_a[%0d]", i), 64'(a_illegal_cnt), 64'(cnt_a));
      chk($sformatf("class_b[%0d]", i), 64'(b_out_class), 64'(vq[i].cb));
      chk($sformatf("ill_b[%0d]", i), 64'(b_out_illegal), 64'(vq[i].ib));
      chk($sformatf("cnt_b[%0d]", i), 64'(b_illegal_cnt), 64'(cnt_b));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(a_out_valid), 64'(1'b0));

    // ---------------- backpressure: 2 accepted, third waits, order kept
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00A00093; in_pc = 32'h200; exp_q.push_back(in_instr);
    tick();
    chk("bp_valid_1", 64'(a_out_valid), 64'(1'b1));
    chk("bp_ready_1", 64'(a_in_ready), 64'(1'b1));
    in_instr  = 32'h00000000; in_pc = 32'h204; exp_q.push_back(in_instr);
    if (cnt_a != 255) cnt_a++;
    tick();
    chk("bp_ready_full", 64'(a_in_ready), 64'(1'b0));
    chk("bp_head_a", 64'(a_out_instr), 64'(exp_q[0]));
    chk("bp_cnt", 64'(a_illegal_cnt), 64'(cnt_a));
    in_instr  = 32'h0020A023; in_pc = 32'h208; exp_q.push_back(in_instr);
    tick();
    chk("bp_hold_instr", 64'(a_out_instr), 64'(exp_q[0]));
    chk("bp_hold_pc", 64'(a_out_pc), 64'(32'h200));
    chk("bp_hold_ready", 64'(a_in_ready), 64'(1'b0));
    tick();
    chk("bp_hold_instr2", 64'(a_out_instr), 64'(exp_q[0]));
    chk("bp_hold_class", 64'(a_out_class), 64'(11'h002));
    out_ready = 1'b1;
    tick();
    void'(exp_q.pop_front());
    chk("bp_second", 64'(a_out_instr), 64'(exp_q[0]));
    chk("bp_second_ill", 64'(a_out_illegal), 64'(1'b1));
    chk("bp_ready_back", 64'(a_in_ready), 64'(1'b1));
    tick();
    void'(exp_q.pop_front());
    chk("bp_third", 64'(a_out_instr), 64'(exp_q[0]));
    chk("bp_third_pc", 64'(a_out_pc), 64'(32'h208));
    void'(exp_q.pop_front());
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 64'(a_out_valid), 64'(1'b0));
    chk("bp_cnt_end", 64'(a_illegal_cnt), 64'(cnt_a));

    // ---------------- flush with full buffer and a pending beat
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00A00093; in_pc = 32'h300;
    tick();
    in_instr  = 32'h0000A103; in_pc = 32'h304;
    tick();
    in_instr  = 32'h00000000; in_pc = 32'h308;
    flush = 1'b1;
    #1;
    chk("fl_ready_low", 64'(a_in_ready), 64'(1'b0));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl_valid", 64'(a_out_valid), 64'(1'b0));
    chk("fl_ready", 64'(a_in_ready), 64'(1'b1));
    chk("fl_cnt", 64'(a_illegal_cnt), 64'(cnt_a));
    in_valid = 1'b1; in_instr = 32'h0020A023; in_pc = 32'h30C; out_ready = 1'b1;
    tick();
    chk("fl_next_instr", 64'(a_out_instr), 64'(32'h0020A023));
    chk("fl_next_pc", 64'(a_out_pc), 64'(32'h30C));
    // flush at cnt=1 with ready otherwise high: beat and pop both dropped
    in_instr = 32'h00000000; in_pc = 32'h310; flush = 1'b1;
    #1;
    chk("fl1_ready_low", 64'(a_in_ready), 64'(1'b0));
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("fl1_valid", 64'(a_out_valid), 64'(1'b0));
    chk("fl1_cnt", 64'(a_illegal_cnt), 64'(cnt_a));

    // ---------------- reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1; in_instr = 32'h00000000; in_pc = 32'h400;
    tick();
    if (cnt_a != 255) cnt_a++;
    chk("mr_cnt_pre", 64'(a_illegal_cnt), 64'(cnt_a));
    chk("mr_valid_pre", 64'(a_out_valid), 64'(1'b1));
    rst = 1'b1;
    #1;
    chk("mr_ready_in_rst", 64'(a_in_ready), 64'(1'b0));
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mr_valid", 64'(a_out_valid), 64'(1'b0));
    chk("mr_ready", 64'(a_in_ready), 64'(1'b1));
    chk("mr_cnt_a", 64'(a_illegal_cnt), 64'(8'h0));
    chk("mr_cnt_b", 64'(b_illegal_cnt), 64'(2'h0));
    chk("mr_instr", 64'(a_out_instr), 64'(32'h0));
    chk("mr_class", 64'(a_out_class), 64'(11'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
